// File: rtl/prefetch_pc_gen_pkg.sv
// prefetch_pc_gen_pkg: shared state encodings and defaults for the prefetch PC generator.
package prefetch_pc_gen_pkg;

    typedef enum logic [1:0] {
        PREPC_IDLE = 2'd0,
        PREPC_REQ  = 2'd1,
        PREPC_WAIT = 2'd2
    } prepc_state_e;

    localparam int          PREPC_ADDR_W  = 64;
    localparam logic [63:0] PREPC_PC_INIT = 64'h8000_0000;
    localparam int          PREPC_PERF_W  = 32;

endpackage

// File: rtl/jump_addr_fifo.sv
// jump_addr_fifo: small synchronous FIFO of jump targets with wrap-bit pointers.
// Head data is read combinationally from storage; any DEPTH >= 1 is supported.
module jump_addr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] WData,
    input  logic             WInc,
    output logic             WFull,
    output logic [WIDTH-1:0] RData,
    input  logic             RInc,
    output logic             REmpty
);

    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [2**IW];
    logic [IW:0]      wptr_q, wptr_d, rptr_q, rptr_d;

    // Index wraps at DEPTH (not 2**IW) so non-power-of-two depths work; the top bit flips per lap.
    function automatic logic [IW:0] nxt(input logic [IW:0] p);
        return (p[IW-1:0] == IW'(DEPTH - 1)) ? {~p[IW], {IW{1'b0}}} : p + (IW+1)'(1);
    endfunction

    assign WFull  = (wptr_q[IW-1:0] == rptr_q[IW-1:0]) && (wptr_q[IW] != rptr_q[IW]);
    assign REmpty = wptr_q == rptr_q;
    assign RData  = mem_q[rptr_q[IW-1:0]];
    assign wptr_d = (WInc && !WFull) ? nxt(wptr_q) : wptr_q;
    assign rptr_d = (RInc && !REmpty) ? nxt(rptr_q) : rptr_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (WInc && !WFull) mem_q[wptr_q[IW-1:0]] <= WData;
    end

endmodule

// File: rtl/prefetch_pc_gen.sv
// prefetch_pc_gen: blocking fetch-request generator with a queued-jump redirect FIFO.
// Perf counters are built only when ANFIELD_PREPC_PERF_EN is defined.
module prefetch_pc_gen
    import prefetch_pc_gen_pkg::*;
#(
    parameter int                ADDR_W      = PREPC_ADDR_W,
    parameter int                FETCH_BYTES = 4,
    parameter int                JUMP_DEPTH  = 2,
    parameter logic [ADDR_W-1:0] PC_INIT     = ADDR_W'(PREPC_PC_INIT)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    JumpValid,
    input  logic [ADDR_W-1:0]       JumpAddr,
    output logic                    JumpReady,
    input  logic                    CacheFull,
    output logic                    ReqValid,
    output logic [ADDR_W-1:0]       ReqAddr,
    input  logic                    ReqReady,
    input  logic                    RespValid,
    output logic                    JumpPending,
    output logic [PREPC_PERF_W-1:0] PerfReqCnt,
    output logic [PREPC_PERF_W-1:0] PerfJumpCnt
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(FETCH_BYTES);
    localparam logic [ADDR_W-1:0] MASK   = ~(STRIDE - ADDR_W'(1));

    prepc_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, head;
    logic              req_valid_q, full, empty, pop;

    jump_addr_fifo #(.WIDTH(ADDR_W), .DEPTH(JUMP_DEPTH)) u_fifo (
        .Clk    (Clk),
        .Rst    (Rst),
        .WData  (JumpAddr & MASK),
        .WInc   (JumpValid && !full),
        .WFull  (full),
        .RData  (head),
        .RInc   (pop),
        .REmpty (empty)
    );

    assign JumpReady   = !full;
    assign JumpPending = !empty;
    assign ReqValid    = req_valid_q;
    assign ReqAddr     = addr_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pop     = 1'b0;
        case (state_q)
            PREPC_REQ: state_d = ReqReady ? PREPC_WAIT : PREPC_REQ;
            PREPC_WAIT: if (RespValid) begin
                pop     = !empty;
                addr_d  = empty ? addr_q + STRIDE : head;
                state_d = CacheFull ? PREPC_IDLE : PREPC_REQ;
            end
            // IDLE keeps the precomputed address unless a jump arrived meanwhile.
            default: if (!CacheFull) begin
                pop     = !empty;
                addr_d  = empty ? addr_q : head;
                state_d = PREPC_REQ;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= PREPC_REQ;
            addr_q      <= PC_INIT;
            req_valid_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            req_valid_q <= state_d == PREPC_REQ;
        end
    end

`ifdef ANFIELD_PREPC_PERF_EN
    logic [PREPC_PERF_W-1:0] req_cnt_q, jump_cnt_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            req_cnt_q  <= '0;
            jump_cnt_q <= '0;
        end else begin
            if (req_valid_q && ReqReady) req_cnt_q <= req_cnt_q + PREPC_PERF_W'(1);
            if (pop) jump_cnt_q <= jump_cnt_q + PREPC_PERF_W'(1);
        end
    end

    assign PerfReqCnt  = req_cnt_q;
    assign PerfJumpCnt = jump_cnt_q;
`else
    assign PerfReqCnt  = '0;
    assign PerfJumpCnt = '0;
`endif

endmodule

// File: tb/tb_prefetch_pc_gen.sv
// tb_prefetch_pc_gen: vector table, corner sequences and random stimulus against a queue-based model.
module tb_prefetch_pc_gen;

    localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2;
    localparam int JD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_jv, a_rr, a_resp, a_cf, a_jready, a_rv, a_jpend;
    logic [63:0] a_jaddr, a_addr;
    logic [31:0] a_preq, a_pjmp;
    logic        b_rst, b_jv, b_rr, b_resp, b_cf, b_jready, b_rv, b_jpend;
    logic [63:0] b_jaddr, b_addr;
    logic [31:0] b_preq, b_pjmp;

    prefetch_pc_gen u0 (
        .Clk(clk), .Rst(a_rst), .JumpValid(a_jv), .JumpAddr(a_jaddr), .JumpReady(a_jready),
        .CacheFull(a_cf), .ReqValid(a_rv), .ReqAddr(a_addr), .ReqReady(a_rr), .RespValid(a_resp),
        .JumpPending(a_jpend), .PerfReqCnt(a_preq), .PerfJumpCnt(a_pjmp)
    );

    prefetch_pc_gen #(.FETCH_BYTES(16), .JUMP_DEPTH(1)) u1 (
        .Clk(clk), .Rst(b_rst), .JumpValid(b_jv), .JumpAddr(b_jaddr), .JumpReady(b_jready),
        .CacheFull(b_cf), .ReqValid(b_rv), .ReqAddr(b_addr), .ReqReady(b_rr), .RespValid(b_resp),
        .JumpPending(b_jpend), .PerfReqCnt(b_preq), .PerfJumpCnt(b_pjmp)
    );

    int checks = 0, failures = 0;

    int          m_ph;
    logic [63:0] m_pc;
    logic [63:0] m_q[$];
    int unsigned m_nreq, m_njmp;

    typedef struct {
        logic jv; logic [63:0] jaddr; logic rr, resp, cf;
        logic rv; logic [63:0] addr; logic jready, jpend;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic jv, input logic [63:0] jaddr, input logic rr, input logic resp,
                       input logic cf, input logic rv, input logic [63:0] addr, input logic jr,
                       input logic jp);
        vec_t v;
        v = '{jv, jaddr, rr, resp, cf, rv, addr, jr, jp};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pexp(input int unsigned v);
`ifdef ANFIELD_PREPC_PERF_EN
        return 64'(v);
`else
        return 64'(v) & 64'd0;
`endif
    endfunction

    task automatic model_reset();
        m_ph = PH_REQ;
        m_pc = 64'h8000_0000;
        m_q.delete();
        m_nreq = 0;
        m_njmp = 0;
    endtask

    // Each rule applies to the queue as it stood before the edge; pushes land afterwards.
    task automatic model_step();
        bit push;
        push = a_jv && (m_q.size() < JD);
        if (m_ph == PH_REQ) begin
            if (a_rr) begin m_ph = PH_WAIT; m_nreq++; end
        end else if (m_ph == PH_WAIT) begin
            if (a_resp) begin
                if (m_q.size() > 0) begin m_pc = m_q.pop_front(); m_njmp++; end
                else m_pc = m_pc + 64'd4;
                m_ph = a_cf ? PH_IDLE : PH_REQ;
            end
        end else if (!a_cf) begin
            if (m_q.size() > 0) begin m_pc = m_q.pop_front(); m_njmp++; end
            m_ph = PH_REQ;
        end
        if (push) m_q.push_back(a_jaddr & ~64'd3);
    endtask

    task automatic check_model();
        chk("model_rv", a_rv, 64'(m_ph == PH_REQ));
        chk("model_addr", a_addr, m_pc);
        chk("model_jready", a_jready, 64'(m_q.size() < JD));
        chk("model_jpend", a_jpend, 64'(m_q.size() != 0));
        chk("model_perf_req", a_preq, pexp(m_nreq));
        chk("model_perf_jmp", a_pjmp, pexp(m_njmp));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic a_set(input logic jv, input logic [63:0] ja, input logic rr, input logic resp,
                         input logic cf);
        a_jv = jv; a_jaddr = ja; a_rr = rr; a_resp = resp; a_cf = cf;
    endtask

    initial begin
        a_rst = 0; b_rst = 0;
        a_set(0, 0, 0, 0, 0);
        b_jv = 0; b_jaddr = 0; b_rr = 0; b_resp = 0; b_cf = 0;
        #2 a_rst = 1; b_rst = 1;
        #1;
        chk("rst_rv", a_rv, 1);
        chk("rst_addr", a_addr, 64'h8000_0000);
        chk("rst_jready", a_jready, 1);
        chk("rst_jpend", a_jpend, 0);
        chk("rst_perf_req", a_preq, 0);
        chk("rst_perf_jmp", a_pjmp, 0);
        @(negedge clk);
        @(negedge clk);
        a_rst = 0; b_rst = 0;
        model_reset();

        add(0, 0, 1, 1, 0,  0, 64'h8000_0000, 1, 0);
        add(0, 0, 1, 1, 0,  1, 64'h8000_0004, 1, 0);
        add(0, 0, 1, 1, 0,  0, 64'h8000_0004, 1, 0);
        add(0, 0, 1, 1, 0,  1, 64'h8000_0008, 1, 0);
        add(0, 0, 1, 0, 0,  0, 64'h8000_0008, 1, 0);
        add(1, 64'h8000_1002, 0, 0, 0,  0, 64'h8000_0008, 1, 1);
        add(0, 0, 0, 1, 0,  1, 64'h8000_1000, 1, 0);
        add(0, 0, 1, 0, 0,  0, 64'h8000_1000, 1, 0);
        add(0, 0, 0, 1, 0,  1, 64'h8000_1004, 1, 0);
        add(0, 0, 1, 0, 0,  0, 64'h8000_1004, 1, 0);
        add(1, 64'h100, 0, 0, 0,  0, 64'h8000_1004, 1, 1);
        add(1, 64'h200, 0, 0, 0,  0, 64'h8000_1004, 0, 1);
        add(1, 64'h300, 0, 0, 0,  0, 64'h8000_1004, 0, 1);
        add(0, 0, 0, 1, 0,  1, 64'h100, 1, 1);
        add(0, 0, 1, 0, 0,  0, 64'h100, 1, 1);
        add(0, 0, 0, 1, 0,  1, 64'h200, 1, 0);
        add(0, 0, 0, 0, 1,  1, 64'h200, 1, 0);
        add(0, 0, 1, 0, 1,  0, 64'h200, 1, 0);
        add(0, 0, 0, 1, 1,  0, 64'h204, 1, 0);
        add(0, 0, 0, 0, 1,  0, 64'h204, 1, 0);
        add(0, 0, 0, 0, 0,  1, 64'h204, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            a_set(tbl[i].jv, tbl[i].jaddr, tbl[i].rr, tbl[i].resp, tbl[i].cf);
            cycle();
            chk($sformatf("tbl%0d_rv", i), a_rv, 64'(tbl[i].rv));
            chk($sformatf("tbl%0d_addr", i), a_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_jready", i), a_jready, 64'(tbl[i].jready));
            chk($sformatf("tbl%0d_jpend", i), a_jpend, 64'(tbl[i].jpend));
        end
        chk("tbl_perf_req", a_preq, pexp(7));
        chk("tbl_perf_jmp", a_pjmp, pexp(3));

        // Address wrap from the top of the space.
        a_set(0, 0, 1, 0, 0); cycle();
        a_set(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0); cycle();
        a_set(0, 0, 0, 1, 0); cycle();
        chk("wrap_top", a_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        a_set(0, 0, 1, 0, 0); cycle();
        a_set(0, 0, 0, 1, 0); cycle();
        chk("wrap_zero", a_addr, 64'h0);
        chk("wrap_rv", a_rv, 1);

        // Jump arriving while IDLE overrides the sequential address.
        a_set(0, 0, 1, 0, 0); cycle();
        a_set(0, 0, 0, 1, 1); cycle();
        chk("idle_rv", a_rv, 0);
        a_set(1, 64'hABC0, 0, 0, 1); cycle();
        a_set(0, 0, 0, 0, 0); cycle();
        chk("idle_jump_addr", a_addr, 64'hABC0);
        chk("idle_jump_jpend", a_jpend, 0);

        // Jump pushed on the decision cycle waits for the next decision.
        a_set(0, 0, 1, 0, 0); cycle();
        a_set(1, 64'h7000, 0, 1, 0); cycle();
        chk("late_jump_seq", a_addr, 64'hABC4);
        chk("late_jump_jpend", a_jpend, 1);
        a_set(0, 0, 1, 0, 0); cycle();
        a_set(0, 0, 0, 1, 0); cycle();
        chk("late_jump_applied", a_addr, 64'h7000);
        a_set(0, 0, 0, 0, 0);

        // 16-byte stride, 1-entry FIFO instance.
        b_jv = 1; b_jaddr = 64'h1234; cycle();
        b_jv = 0;
        chk("b_full_jready", b_jready, 0);
        chk("b_full_jpend", b_jpend, 1);
        b_rr = 1; cycle(); b_rr = 0;
        chk("b_wait_rv", b_rv, 0);
        b_resp = 1; cycle(); b_resp = 0;
        chk("b_align_addr", b_addr, 64'h1230);
        chk("b_align_rv", b_rv, 1);
        chk("b_align_jpend", b_jpend, 0);
        b_rr = 1; cycle(); b_rr = 0;
        b_jv = 1; b_jaddr = 64'h5678; cycle(); b_jv = 0;
        chk("b_wait_jpend", b_jpend, 1);
        #1 b_rst = 1;
        #1;
        chk("b_rst_rv", b_rv, 1);
        chk("b_rst_addr", b_addr, 64'h8000_0000);
        chk("b_rst_jpend", b_jpend, 0);
        chk("b_rst_jready", b_jready, 1);
        chk("b_rst_perf_req", b_preq, 0);
        chk("b_rst_perf_jmp", b_pjmp, 0);
        @(negedge clk);
        b_rst = 0;
        cycle();
        chk("b_post_rst_rv", b_rv, 1);
        chk("b_post_rst_addr", b_addr, 64'h8000_0000);

        for (int i = 0; i < 400; i++) begin
            a_set($urandom_range(0, 3) == 0, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prefetch_pc_gen.md
Name: prefetch_pc_gen

Overview:
- Parametrised successor of the single-entry pseudo-PC stage. Generates blocking instruction-fetch requests to the bus ahead of the pipeline PC.
- Redirects to jump addresses queued on cache miss, using a JUMP_DEPTH-entry FIFO. Stalls while the Ifu instruction cache is full.
- Sits between the branch/miss logic and the bus request port. The Ifu matches returned instructions to PCs.

Parameters:
- ADDR_W, 64, width of all addresses.
- FETCH_BYTES, 4, sequential stride in bytes. Must be a power of two, 4 to 16.
- JUMP_DEPTH, 2, number of jump-FIFO entries. Must be at least 1.
- PC_INIT, 64'h8000_0000, first fetch address after reset.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset, asynchronous, active-high.
- JumpValid  in  1  push jump address (cache miss / redirect).
- JumpAddr  in  ADDR_W  jump target.
- JumpReady  out  1  FIFO not full.
- CacheFull  in  1  Ifu cache cannot accept more data.
- ReqValid  out  1  fetch request valid.
- ReqAddr  out  ADDR_W  fetch address, aligned to FETCH_BYTES.
- ReqReady  in  1  bus accepts request.
- RespValid  in  1  bus read data returned (ends the transaction).
- JumpPending  out  1  FIFO non-empty.
- PerfReqCnt  out  32  accepted requests.
- PerfJumpCnt  out  32  redirects taken.

Behaviour:
- Reset (async, Rst=1): state=REQ, ReqValid=1, ReqAddr=PC_INIT, FIFO empty (JumpReady=1, JumpPending=0), counters 0.
- All outputs are registered except JumpReady and JumpPending, which are decoded from FIFO state flops.
- FSM state REQ: ReqValid=1. ReqAddr is held stable until ReqValid&&ReqReady. On that handshake go to WAIT.
- FSM state WAIT: ReqValid=0, waiting for RespValid. When RespValid=1, the next address is decided:
  - If the FIFO is non-empty: pop the head; next=head.
  - Otherwise: next=ReqAddr+FETCH_BYTES, modulo 2^ADDR_W (wraps from all-ones to 0).
  - The next address is loaded into ReqAddr.
  - Then go to IDLE if CacheFull=1, else to REQ.
- FSM state IDLE: ReqValid=0. When CacheFull=0, go to REQ the next cycle; ReqAddr is unchanged.
  - If the FIFO became non-empty while in IDLE, pop the head into ReqAddr on that transition. The jump overrides the precomputed sequential address.
- CacheFull is ignored in REQ, because an asserted request is never withdrawn. CacheFull is also ignored in WAIT until the decision cycle.
- RespValid outside WAIT is ignored. ReqReady outside REQ is ignored.
- FIFO push: on JumpValid&&JumpReady; JumpAddr low log2(FETCH_BYTES) bits are cleared.
  - JumpValid while full is dropped; the producer must hold it.
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - When full, JumpReady=0 even if a pop occurs that cycle, to avoid a combinational path.
- A jump pushed in the same cycle as the WAIT decision is not visible. The sequential address is used and the jump applies at the next decision.
- Latency: minimum 2 cycles between request issues (handshake, then response/decision). Back-to-back issue happens when RespValid arrives the cycle after the handshake.
- Entries pop in order; the oldest jump is applied first.

Optional Feature:
- Macro: ANFIELD_PREPC_PERF_EN.
- Defined: PerfReqCnt increments on each ReqValid&&ReqReady. PerfJumpCnt increments on each FIFO pop. Both are 32-bit counters that wrap and reset to 0.
- Undefined: counter flops are not built and both ports are tied to 0.

Decomposition:
- Shared defines/package holds:
  - FSM state encodings PREPC_IDLE=2'd0, PREPC_REQ=2'd1, PREPC_WAIT=2'd2.
  - Default PC_INIT and ADDR_W.
  - Perf counter width 32.
- Sub-module jump_addr_fifo(WIDTH, DEPTH):
  - Synchronous FIFO with async active-high reset.
  - Ports: WData, WInc, WFull, RData (head, combinational from storage), RInc, REmpty.
  - Pointers are one bit wider than log2(DEPTH); depth 1 is supported.

Test Plan:
- Reset release, ReqReady=1, RespValid the cycle after each handshake, no jumps -> ReqAddr sequence 0x80000000, 0x80000004, 0x80000008. ReqValid is high every other cycle.
- Jump 0x80001002 pushed mid-WAIT, then RespValid -> next ReqAddr=0x80001000 and JumpPending falls. With the perf macro: PerfJumpCnt=1.
- JUMP_DEPTH=2, push 0x100, 0x200, 0x300 on consecutive cycles while in WAIT -> third push sees JumpReady=0. Next two requests are 0x100 then 0x200.
- CacheFull=1 asserted during REQ -> request stays valid until ReqReady. After RespValid go to IDLE with ReqValid=0. CacheFull=0 -> REQ at ReqAddr+4 with ReqAddr stable throughout.
- ReqAddr=0xFFFF_FFFF_FFFF_FFFC with FETCH_BYTES=4, RespValid -> next ReqAddr=0x0. Separately, FETCH_BYTES=16 with jump 0x1234 -> ReqAddr 0x1230.
- Rst asserted for one cycle mid-WAIT with a 1-entry FIFO -> immediate ReqValid=1, ReqAddr=0x80000000, JumpPending=0, counters 0.
